// File: rtl/fir_decim_out.sv
// rtl/fir_decim_out.sv - decimate, round/saturate and buffer FIR output samples
module fir_decim_out #(
   parameter int DECIM = 4,
   parameter int SHIFT = 8,
   parameter int OUT_W = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                data_in,
   input  logic                       data_in_valid,
   input  logic                       clr_flags,
   output logic [OUT_W-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       sat_flag,
   output logic                       ovf_flag
);

   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0]      PHASE_LAST = PW'(DECIM - 1);
   localparam logic [LW-1:0]      LEVEL_FULL = LW'(DEPTH);
   localparam logic signed [32:0] ROUND_ADD  = 33'sd1 <<< (SHIFT - 1);
   localparam logic signed [32:0] SAT_MAX    = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
   localparam logic signed [32:0] SAT_MIN    = -(33'sd1 <<< (OUT_W - 1));

   logic [PW-1:0]      phase_q, phase_d;
   logic               sc_valid_q, sc_valid_d;
   logic [OUT_W-1:0]   sc_data_q, sc_data_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]      level_q, level_d;
   logic               sat_q, sat_d;
   logic               ovf_q, ovf_d;
   logic [OUT_W-1:0]   fifo_q [DEPTH];

   logic               keep;
   logic signed [32:0] rnd_sum;
   logic signed [32:0] shifted;
   logic               clamp_hi;
   logic               clamp_lo;
   logic               push;
   logic               pop;
   logic               full;
   logic               wr_en;

   // FIFO head is presented only when valid so the idle/reset output is zero
   assign out_valid = (level_q != '0);
   assign out_data  = out_valid ? fifo_q[rd_ptr_q] : '0;
   assign level     = level_q;
   assign sat_flag  = sat_q;
   assign ovf_flag  = ovf_q;

   // Decimation phase, round-half-up scaling and clamp of the incoming sample
   always_comb begin
      keep     = data_in_valid && (phase_q == '0);
      rnd_sum  = $signed({data_in[31], data_in}) + ROUND_ADD;
      shifted  = rnd_sum >>> SHIFT;
      clamp_hi = (shifted > SAT_MAX);
      clamp_lo = (shifted < SAT_MIN);

      phase_d = phase_q;
      if (data_in_valid) begin
         phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
      end

      sc_valid_d = keep;
      sc_data_d  = sc_data_q;
      if (keep) begin
         if (clamp_hi) begin
            sc_data_d = SAT_MAX[OUT_W-1:0];
         end else if (clamp_lo) begin
            sc_data_d = SAT_MIN[OUT_W-1:0];
         end else begin
            sc_data_d = shifted[OUT_W-1:0];
         end
      end
   end

   // FIFO pointer/level bookkeeping; a push on full is accepted only alongside a pop
   always_comb begin
      push     = sc_valid_q;
      pop      = out_valid && out_ready;
      full     = (level_q == LEVEL_FULL);
      wr_en    = push && (!full || pop);
      wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q;
      if (wr_en && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !wr_en) begin
         level_d = level_q - LW'(1);
      end
   end

   // Sticky flags: clear first so a same-cycle set event wins
   always_comb begin
      sat_d = sat_q;
      ovf_d = ovf_q;
      if (clr_flags) begin
         sat_d = 1'b0;
         ovf_d = 1'b0;
      end
      if (keep && (clamp_hi || clamp_lo)) begin
         sat_d = 1'b1;
      end
      if (push && full && !pop) begin
         ovf_d = 1'b1;
      end
   end

   // Control and pipeline registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q    <= '0;
         sc_valid_q <= 1'b0;
         sc_data_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         sat_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         sc_valid_q <= sc_valid_d;
         sc_data_q  <= sc_data_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         sat_q      <= sat_d;
         ovf_q      <= ovf_d;
      end
   end

   // FIFO storage; contents are don't-care until the level says otherwise
   always_ff @(posedge clk) begin
      if (wr_en) begin
         fifo_q[wr_ptr_q] <= sc_data_q;
      end
   end

endmodule

// File: doc/fir_decim_out.md
# fir_decim_out

Output stage placed directly downstream of the 15-tap FIR filter. It consumes the filter's 32-bit signed sample stream (valid-only, no backpressure) and decimates it by a fixed ratio. Each kept sample is scaled by an arithmetic right shift with round-half-up and saturated to a narrower signed word. Results are buffered in a small FIFO and presented on a valid/ready interface to the consumer.

## Interface

Parameters:
- DECIM, 4: decimation ratio, legal 1..16; DECIM=1 keeps every sample.
- SHIFT, 8: right-shift amount for scaling, legal 1..16.
- OUT_W, 16: output word width, legal 8..32.
- DEPTH, 4: FIFO entries, power of two, legal 2..16.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- data_in  input  32  signed FIR output sample.
- data_in_valid  input  1  data_in is a new sample this cycle.
- clr_flags  input  1  synchronous clear of sat_flag and ovf_flag.
- out_data  output  OUT_W  signed scaled sample at FIFO head.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- level  output  $clog2(DEPTH+1)  current FIFO occupancy.
- sat_flag  output  1  sticky: a kept sample saturated.
- ovf_flag  output  1  sticky: a scaled sample was dropped because the FIFO was full.

## Operation

- Reset (rst=0, asynchronous) clears:
  - phase counter;
  - scale-stage valid;
  - FIFO pointers and level;
  - out_valid, sat_flag, ovf_flag (all 0);
  - out_data (0).
- Phase counter:
  - Advances only on cycles with data_in_valid=1, counting 0..DECIM-1 and wrapping to 0.
  - A sample is kept when phase==0 at that cycle. The first valid sample after reset is kept, then every DECIM-th sample after it.
  - Cycles with data_in_valid=0 change nothing.
- Scale stage (one register):
  - t = sign-extend data_in to 33 bits + 2^(SHIFT-1).
  - s = t >>> SHIFT (arithmetic shift).
  - If s > 2^(OUT_W-1)-1, the result is 2^(OUT_W-1)-1; if s < -2^(OUT_W-1), the result is -2^(OUT_W-1). Otherwise the result is s truncated to OUT_W bits.
  - Any clamp sets sat_flag.
  - Rounding is round-half-toward-+inf for both signs.
- FIFO:
  - Push = scale-stage valid. Pop = out_valid & out_ready.
  - Push on full with no pop: sample dropped, ovf_flag set, FIFO unchanged.
  - Push and pop in the same cycle, at any level including full: both take effect and level is unchanged.
  - Pop on empty cannot occur, because out_valid=0.
  - Pointers wrap modulo DEPTH.
  - out_data is the head entry. It stays stable while out_valid=1 and out_ready=0.
- Flags:
  - clr_flags=1 clears both flags on the next edge.
  - If a set event and clr_flags occur in the same cycle, set wins.

## Timing

- Latency: a kept sample sampled at edge E0 is in the scale register after E0. It is written to the FIFO at E1, so out_valid=1 and out_data are visible after E1. If the FIFO was empty, latency is 2 cycles from input to output.
- There is no combinational path from data_in or out_ready to any output.
- Throughput: one kept sample per cycle (DECIM=1) is sustained when out_ready is held at 1.
- level updates on the same edge as the push/pop it reflects.
- Reset asserted mid-stream discards all buffered and in-flight samples. The first valid sample after rst returns to 1 is kept (phase restarts at 0).

## Test plan

- Decimation: DECIM=4, out_ready=1, ramp input 0,256,512,… (one sample per cycle) → outputs 0,4,8,12 (inputs 0,1024,2048,3072). Outputs are spaced 4 cycles apart and the first out_valid appears 2 cycles after the first input. Inserting data_in_valid=0 gaps does not change which samples are kept.
- Rounding: DECIM=1, inputs 384, -384, 127, 128, -129 → outputs 2, -1, 0, 1, -1. sat_flag stays 0.
- Saturation: inputs 0x7FFFFFFF and 0x80000000 → outputs 32767 and -32768, and sat_flag=1. clr_flags pulse → sat_flag=0 on the next cycle.
- Backpressure: DECIM=1, out_ready=0, 6 consecutive valid inputs → level reaches 4 and ovf_flag=1. The first 4 samples are then drained in order with out_data stable while stalled, and the last 2 samples are absent.
- Full with simultaneous push/pop: at level=4, hold out_ready=1 while inputs continue → level stays 4, no drop, ovf_flag stays 0, and output order is preserved.
- Reset mid-operation: with 3 entries buffered and phase=2, pulse rst low asynchronously between edges → out_valid, level and flags are 0 immediately. The next valid input after release is kept.
